// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_REL    = 3'd3,
        S_RUN    = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // Width of the single shared counter: must hold the largest terminal count.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the PLL through reset/lock/stabilise, then releases downstream domain
// resets in ascending order; restarts on lock loss or soft request.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GAP_CYCLES    = 8,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   locked,
    input  logic                   soft_rst_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   ready,
    output logic                   fail,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, GAP_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [RW-1:0]           retry_reg, retry_next;
    logic [NUM_DOMAINS-1:0]  rel_reg, rel_next;
    logic [LOSS_CNT_W-1:0]   loss_cnt_reg, loss_cnt_next;
    logic                    lock_s;
    logic                    lock_loss;
    logic                    restart;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (lock_s)
    );

    assign lock_loss = !lock_s && (state_reg == S_REL || state_reg == S_RUN);
    assign restart   = (state_reg != S_FAIL) && (soft_rst_req || lock_loss);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + CW'(1);
        retry_next    = retry_reg;
        rel_next      = rel_reg;
        loss_cnt_next = loss_cnt_reg;

        if (restart) begin
            state_next = S_PLLRST;
            cnt_next   = '0;
            rel_next   = '0;
            if (lock_loss && loss_cnt_reg != {LOSS_CNT_W{1'b1}})
                loss_cnt_next = loss_cnt_reg + LOSS_CNT_W'(1);
            if (soft_rst_req)
                retry_next = '0;
        end else begin
            case (state_reg)
                S_PLLRST: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = S_WAIT;
                        cnt_next   = '0;
                    end
                end
                S_WAIT: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s) begin
                        state_next = S_STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TO_LAST) begin
                        cnt_next   = '0;
                        retry_next = retry_reg + RW'(1);
                        state_next = (retry_reg + RW'(1) == RETRY_MAX) ? S_FAIL : S_PLLRST;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_next = S_WAIT;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = S_REL;
                        cnt_next   = '0;
                        retry_next = '0;
                        rel_next   = NUM_DOMAINS'(1);
                    end
                end
                S_REL: begin
                    // Release mask is a thermometer code, so order is ascending by construction.
                    if (cnt_reg == GAP_LAST) begin
                        cnt_next = '0;
                        if (rel_reg[NUM_DOMAINS-1])
                            state_next = S_RUN;
                        else
                            rel_next = (rel_reg << 1) | NUM_DOMAINS'(1);
                    end
                end
                S_RUN: begin
                    cnt_next = '0;
                end
                S_FAIL: begin
                    cnt_next = '0;
                    rel_next = '0;
                end
                default: begin
                    state_next = S_PLLRST;
                    cnt_next   = '0;
                    rel_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_PLLRST;
            cnt_reg      <= '0;
            retry_reg    <= '0;
            rel_reg      <= '0;
            loss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            retry_reg    <= retry_next;
            rel_reg      <= rel_next;
            loss_cnt_reg <= loss_cnt_next;
        end
    end

    // Lock loss pulls every domain back into reset in the same cycle it is seen.
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        assign dom_rst_n[gi] = rel_reg[gi] & ~lock_loss;
    end

    assign pll_rst       = (state_reg == S_PLLRST) || (state_reg == S_FAIL);
    assign ready         = (state_reg == S_RUN);
    assign fail          = (state_reg == S_FAIL);
    assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: phase/elapsed-time reference model, directed scenarios
// with hand-computed timing, and a randomized lock/soft-request soak.
module tb_pll_lock_sequencer;

    localparam int ND   = 2;
    localparam int RST  = 4;
    localparam int TO   = 20;
    localparam int STB  = 10;
    localparam int GAP  = 3;
    localparam int MAXR = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;
    localparam int P_FAIL = 5;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          locked = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] dom_rst_n;
    logic          ready;
    logic          fail;
    logic [7:0]    lock_loss_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: phase, edges elapsed in phase, consecutive timeouts, losses.
    int ph;
    int t;
    int attempts;
    int losses;
    bit hist[$];

    pll_lock_sequencer #(
        .NUM_DOMAINS   (ND),
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .GAP_CYCLES    (GAP),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .locked        (locked),
        .soft_rst_req  (soft_rst_req),
        .pll_rst       (pll_rst),
        .dom_rst_n     (dom_rst_n),
        .ready         (ready),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Synchronised lock as seen after the latest edge: locked sampled one edge earlier.
    function automatic bit ls_m();
        return (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    endfunction

    function automatic void model_reset();
        ph = P_RST;
        t = 0;
        attempts = 0;
        losses = 0;
        hist.delete();
    endfunction

    function automatic int exp_dom();
        int r;
        if (ph == P_REL)      r = t / GAP + 1;
        else if (ph == P_RUN) r = ND;
        else                  r = 0;
        if (!ls_m() && (ph == P_REL || ph == P_RUN)) r = 0;
        return (1 << r) - 1;
    endfunction

    task automatic model_step();
        bit ls;
        bit loss;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = ls_m();
        loss = !ls && (ph == P_REL || ph == P_RUN);
        if (ph != P_FAIL && (soft_rst_req || loss)) begin
            if (loss) losses++;
            if (soft_rst_req) attempts = 0;
            ph = P_RST;
            t = 0;
        end else begin
            t++;
            case (ph)
                P_RST:  if (t == RST) begin ph = P_WAIT; t = 0; end
                P_WAIT: begin
                    if (ls) begin
                        ph = P_STAB; t = 0;
                    end else if (t == TO) begin
                        attempts++;
                        ph = (attempts == MAXR) ? P_FAIL : P_RST;
                        t = 0;
                    end
                end
                P_STAB: begin
                    if (!ls) begin
                        ph = P_WAIT; t = 0;
                    end else if (t == STB) begin
                        ph = P_REL; t = 0; attempts = 0;
                    end
                end
                P_REL:  if (t == ND * GAP) begin ph = P_RUN; t = 0; end
                default: ;
            endcase
        end
        hist.push_back(locked);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic check();
        chk("pll_rst", pll_rst, (ph == P_RST || ph == P_FAIL));
        chk("dom_rst_n", dom_rst_n, exp_dom());
        chk("ready", ready, (ph == P_RUN));
        chk("fail", fail, (ph == P_FAIL));
        chk("lock_loss_cnt", lock_loss_cnt, (losses > 255) ? 255 : losses);
    endtask

    task automatic cycle();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit ok;

        model_reset();
        #1;
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_dom_rst_n", dom_rst_n, 0);
        chk("reset_ready", ready, 0);
        chk("reset_fail", fail, 0);
        chk("reset_loss_cnt", lock_loss_cnt, 0);
        @(negedge refclk);

        // Nominal bring-up with hand-computed timing.
        do_reset();
        locked = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (pll_rst && n < 50);
        chk("t1_pllrst_len", n, RST);
        repeat (4) cycle();
        locked = 1'b1;
        cycle();  // first edge that samples locked high
        n = 0;
        do begin cycle(); n++; end while (!dom_rst_n[0] && n < 50);
        chk("t1_dom0_delay", n, 2 + STB);
        chk("t1_dom1_held", dom_rst_n[1], 0);
        n = 0;
        do begin cycle(); n++; end while (!dom_rst_n[1] && n < 50);
        chk("t1_dom1_delay", n, GAP);
        chk("t1_not_ready_yet", ready, 0);
        n = 0;
        do begin cycle(); n++; end while (!ready && n < 50);
        chk("t1_ready_delay", n, GAP);

        // One-cycle lock drop from S_RUN.
        locked = 1'b0;
        cycle();
        locked = 1'b1;
        cycle();
        chk("t3_dom_forced", dom_rst_n, 0);
        chk("t3_ready_hold", ready, 1);
        cycle();
        chk("t3_ready_drop", ready, 0);
        chk("t3_pll_rst", pll_rst, 1);
        chk("t3_loss_cnt", lock_loss_cnt, 1);
        n = 0;
        do begin cycle(); n++; end while (!ready && n < 100);
        chk("t3_replay_ready", ready, 1);

        // Soft restart, then a glitch during stabilisation restarts the stable count.
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        chk("t4_soft_pll_rst", pll_rst, 1);
        chk("t4_soft_loss_cnt", lock_loss_cnt, 1);
        repeat (9) cycle();
        locked = 1'b0;
        cycle();
        locked = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!dom_rst_n[0] && n < 50);
        chk("t4_glitch_release", n, 1 + 2 + STB);

        // Soft request in S_REL after domain 0 is released.
        chk("t5_pre_dom", dom_rst_n, 1);
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        chk("t5_dom_reset", dom_rst_n, 0);
        chk("t5_pll_rst", pll_rst, 1);
        chk("t5_loss_cnt", lock_loss_cnt, 1);
        n = 0;
        do begin cycle(); n++; end while (!ready && n < 100);
        chk("t5_ready_again", ready, 1);

        // No lock ever: two attempts of RST+TO cycles, then sticky fail.
        do_reset();
        locked = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!fail && n < 200);
        chk("t2_fail_time", n, MAXR * (RST + TO));
        chk("t2_pll_rst", pll_rst, 1);
        chk("t2_ready", ready, 0);
        locked = 1'b1;
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        repeat (20) cycle();
        chk("t2_fail_sticky", fail, 1);
        chk("t2_pll_rst_sticky", pll_rst, 1);

        // Asynchronous reset in the middle of stabilisation.
        do_reset();
        locked = 1'b1;
        repeat (9) cycle();
        chk("async_pre_dom", dom_rst_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pll_rst", pll_rst, 1);
        chk("async_dom_rst_n", dom_rst_n, 0);
        chk("async_ready", ready, 0);
        chk("async_fail", fail, 0);
        chk("async_loss_cnt", lock_loss_cnt, 0);
        model_reset();
        cycle();
        rst_n = 1'b1;

        // Randomized soak.
        locked = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (locked) begin
                if ($urandom_range(0, 99) < 3) locked = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 12) locked = 1'b1;
            end
            soft_rst_req = ($urandom_range(0, 99) < 1);
            cycle();
            soft_rst_req = 1'b0;
            if (ph == P_FAIL && $urandom_range(0, 9) == 0) do_reset();
        end

        // Repeated lock losses saturate the counter.
        do_reset();
        locked = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 300 && ok; i++) begin
            n = 0;
            do begin cycle(); n++; end while (!dom_rst_n[0] && n < 100);
            if (!dom_rst_n[0]) begin
                chk("t6_release_timeout", dom_rst_n[0], 1);
                ok = 1'b0;
            end else begin
                locked = 1'b0;
                repeat (3) cycle();
                locked = 1'b1;
            end
        end
        repeat (5) cycle();
        chk("t6_loss_saturated", lock_loss_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
